// File: rtl/fpadd_scheduler.sv
// fpadd_scheduler: arbitrates NREQ requesters onto one shared FP adder; FPADD_SCHED_FIXED_PRIO_EN selects fixed priority over round-robin.
module fpadd_scheduler #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic [XLEN-1:0]      add_a,
  output logic [XLEN-1:0]      add_b,
  input  logic [XLEN-1:0]      add_result,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IW-1:0] g, gnt;
  logic [2:0] cnt;
  logic any;
  logic [XLEN-1:0] sel_a, sel_b;
`ifdef FPADD_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i]) begin
        gnt = IW'(i);
        any = 1'b1;
      end
  end
`else
  logic [IW-1:0] last_grant;
  // second pass overrides the first, so indices above last_grant win before wrapping
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i] && IW'(i) <= last_grant) begin
        gnt = IW'(i);
        any = 1'b1;
      end
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i] && IW'(i) > last_grant) begin
        gnt = IW'(i);
        any = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (rst) last_grant <= IW'(NREQ - 1);
    else if (state == IDLE && any) last_grant <= gnt;
`endif
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt == IW'(i)) begin
        sel_a = req_a[i*XLEN +: XLEN];
        sel_b = req_b[i*XLEN +: XLEN];
      end
  end
  assign req_ready = (state == IDLE && any) ? NREQ'(1) << gnt : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_valid <= '0;
      rsp_data <= '0;
      add_a <= '0;
      add_b <= '0;
      cnt <= '0;
      g <= '0;
    end else begin
      unique case (state)
        IDLE: if (any) begin
          add_a <= sel_a;
          add_b <= sel_b;
          g <= gnt;
          cnt <= 3'(LAT);
          state <= EXEC;
        end
        EXEC: if (cnt == 3'd0) begin
          rsp_data <= add_result;
          rsp_valid <= NREQ'(1) << g;
          state <= RESP;
        end else cnt <= cnt - 3'd1;
        RESP: if (rsp_ready[g]) begin
          rsp_valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_scheduler.sv
// tb_fpadd_scheduler: directed and random transactions against a transaction-level model with a table-driven adder stub.
module tb_fpadd_scheduler;
  localparam int XLEN = 32, NREQ = 4, LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [NREQ*XLEN-1:0] req_a = '0, req_b = '0;
  logic [XLEN-1:0] rsp_data, add_a, add_b, add_result;
  logic busy;
  int vectors = 0, miscompares = 0, last = NREQ - 1;
  int opk [NREQ];
  logic [31:0] ta [8] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h40A00000,
                          32'hC0000000, 32'h3F000000, 32'h41200000, 32'h00000000};
  logic [31:0] tbv [8] = '{32'h40000000, 32'hBF000000, 32'h3F800000, 32'h40A00000,
                           32'h3F800000, 32'h3F000000, 32'h40000000, 32'h42C80000};
  logic [31:0] ts [8] = '{32'h40400000, 32'h3F800000, 32'h40800000, 32'h41200000,
                          32'hBF800000, 32'h3F800000, 32'h41400000, 32'h42C80000};
  logic [XLEN-1:0] pipe [LAT];

  fpadd_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    fadd = 32'hFFC00001;
    for (int k = 0; k < 8; k++)
      if (ta[k] === a && tbv[k] === b) fadd = ts[k];
  endfunction

  // shared adder: result appears LAT edges after the operands change
  always @(posedge clk) begin
    pipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[LAT-1];

  function automatic int pick(input logic [NREQ-1:0] mask);
    pick = -1;
`ifdef FPADD_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (mask[i]) pick = i;
`else
    for (int k = NREQ; k >= 1; k--) if (mask[(last + k) % NREQ]) pick = (last + k) % NREQ;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ops(input int i, input int k);
    req_a[i*XLEN +: XLEN] = ta[k];
    req_b[i*XLEN +: XLEN] = tbv[k];
    opk[i] = k;
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 7));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    last = NREQ - 1;
  endtask

  // called while IDLE, just after a falling edge; returns in IDLE just after a falling edge
  task automatic transact(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] during, input int hold);
    int g;
    logic [NREQ-1:0] oh;
    logic [31:0] ea, eb, es;
    rsp_ready = '0;
    req_valid = mask;
    #1;
    g = pick(mask);
    oh = '0;
    oh[g] = 1'b1;
    chk("grant", req_ready, oh);
    chk("idle_busy", busy, 0);
    ea = ta[opk[g]];
    eb = tbv[opk[g]];
    es = ts[opk[g]];
    last = g;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk); #1;
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_req_ready", req_ready, 0);
      chk("exec_busy", busy, 1);
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      if (c == 1) begin
        req_valid = during;
        scramble();
      end
    end
    @(negedge clk); #1;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, es);
    chk("resp_req_ready", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = NREQ'($urandom) & ~oh;
      @(negedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, oh);
      chk("hold_rsp_data", rsp_data, es);
      chk("hold_busy", busy, 1);
      chk("hold_add_a", add_a, ea);
    end
    rsp_ready = oh | NREQ'($urandom);
    @(negedge clk); #1;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_ops(i, 0);
    do_reset();
    set_ops(0, 0);
    transact(4'b0001, 4'b0000, 0);
    set_ops(2, 1);
    transact(4'b0100, 4'b0000, 5);
    set_ops(3, 2);
    set_ops(1, 3);
    transact(4'b1000, 4'b1010, 1);
    set_ops(1, 3);
    transact(4'b0010, 4'b0010, 0);
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, (i + r) % 8);
      transact(4'b1111, 4'b1111, 0);
    end
    do_reset();
    set_ops(2, 4);
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", req_ready, 4'b0100);
    @(negedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    last = NREQ - 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    for (int i = 0; i < NREQ; i++) set_ops(i, 6 - i);
    transact(4'b1111, 4'b0000, 0);
    for (int n = 0; n < 40; n++) begin
      scramble();
      transact(NREQ'($urandom_range(1, (1 << NREQ) - 1)), NREQ'($urandom), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fpadd_scheduler.md
FPADD_SCHEDULER -- requirements
Module: fpadd_scheduler

Interface
REQ-001 Parameter XLEN, 32: operand/result width in bits, IEEE-754 single-precision format.
REQ-002 Parameter NREQ, 4: number of requesters, range 2..8.
REQ-003 Parameter LAT, 1: adder result latency in clock edges, range 1..4.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  one-hot acceptance; a bit is high only while the matching req_valid bit is high.
REQ-009 req_a  in  NREQ*XLEN  operand A; requester i occupies bits [i*XLEN +: XLEN].
REQ-010 req_b  in  NREQ*XLEN  operand B; same packing as req_a.
REQ-011 rsp_valid  out  NREQ  one-hot result-available flag.
REQ-012 rsp_ready  in  NREQ  per-requester result acceptance.
REQ-013 rsp_data  out  XLEN  result, shared by all requesters, qualified by rsp_valid.
REQ-014 add_a, add_b  out  XLEN  registered operands driven to the shared adder.
REQ-015 add_result  in  XLEN  shared adder output, valid LAT edges after add_a/add_b change.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 IDLE: when any req_valid bit is high, assert req_ready for exactly one granted index g in that cycle.
REQ-019 On the accept edge, load req_a/req_b slice g into add_a/add_b, store g, load the counter with LAT, and enter EXEC.
REQ-020 EXEC: decrement the counter each edge; on the edge where the counter is 0, latch add_result into rsp_data, set rsp_valid[g], and enter RESP.
REQ-021 With LAT=1, rsp_valid SHALL first be high 3 cycles after the accept cycle.
REQ-022 add_a/add_b SHALL remain stable from the accept edge until the next accept edge.
REQ-023 RESP: hold rsp_valid[g] and rsp_data until rsp_ready[g] is high, then clear rsp_valid and return to IDLE on that edge.
REQ-024 rsp_ready bits for indices other than g SHALL be ignored.
REQ-025 req_ready SHALL be all-zero in EXEC and RESP, so at most one operation is in flight.
REQ-026 Round-robin arbitration: search from index last_grant+1 upward, wrapping from NREQ-1 to 0; last_grant updates on each accept.
REQ-027 A lone requester SHALL be granted on every turn.
REQ-028 The block SHALL not alter operand or result bits: no sign, exponent or mantissa manipulation.
REQ-029 A requester deasserting req_valid before it is granted SHALL cause no side effect.

Reset
REQ-030 On a rst edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, add_a=add_b=0, counter=0, busy=0, last_grant=NREQ-1.
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid pulse follows it.
REQ-032 rst has priority over all other events in the same cycle.

Configuration
REQ-033 Macro FPADD_SCHED_FIXED_PRIO_EN defined: fixed priority arbitration, where the lowest asserted index always wins and last_grant is unused.
REQ-034 Macro FPADD_SCHED_FIXED_PRIO_EN undefined (default): round-robin arbitration per REQ-026.

Verification
REQ-035 Requester 0 sends A=0x3F800000, B=0x40000000 (LAT=1) -> req_ready[0] in the same cycle; rsp_valid[0] 3 cycles later; rsp_data=0x40400000.
REQ-036 Requester 2 sends 0x3FC00000 + 0xBF000000 while rsp_ready[2] is held low for 5 cycles -> rsp_valid[2] and rsp_data=0x3F800000 stay stable for 5 cycles; the block returns to IDLE after rsp_ready[2] rises.
REQ-037 All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0 (round-robin build); 0,0,0 (fixed-priority build).
REQ-038 Reset asserted 1 cycle after acceptance -> no rsp_valid ever appears; busy=0 the next cycle; the next grant goes to index 0.
REQ-039 Requester 1 valid during EXEC for requester 3 -> req_ready stays 0 until IDLE; requester 1 is then granted and receives its own correct sum.
